config_frame_loader: RTL and testbench

- Upstream feeder of the per-tile configuration loaders.
- Accepts a byte-wide framed bitstream over a valid/ready handshake and decodes it into per-tile write strobes. Each strobe is a one-hot select_tile, with address_tile and data_tile broadcast to all tiles.
- Sits at fabric top, clocked by the configuration clock; drives every tile's select_tile/address_tile/data_tile inputs.

---
 rtl/cfg_loader_pkg.sv | 24 ++
 rtl/cfg_onehot_dec.sv | 18 +
 rtl/config_frame_loader.sv | 108 ++++++++++
 tb/tb_config_frame_loader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration frame loader: FSM states,
// end-of-bitstream marker and header field byte offsets.
package cfg_loader_pkg;

    // Frame header layout: T, AH, AL, L, then L+1 data bytes.
    localparam int HDR_OFF_T   = 0;
    localparam int HDR_OFF_AH  = 1;
    localparam int HDR_OFF_AL  = 2;
    localparam int HDR_OFF_LEN = 3;

    localparam logic [7:0] EOB_MARKER = 8'hFF;

    // Header states are numbered in header byte order.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_T   = 3'(1 + HDR_OFF_T),
        HDR_AH  = 3'(1 + HDR_OFF_AH),
        HDR_AL  = 3'(1 + HDR_OFF_AL),
        HDR_LEN = 3'(1 + HDR_OFF_LEN),
        DATA    = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/cfg_onehot_dec.sv
// Index to one-hot decoder gated by an enable; out-of-range indices decode to 0.
module cfg_onehot_dec #(
    parameter int N     = 16,
    parameter int IDX_W = 8
) (
    input  logic [IDX_W-1:0] index,
    input  logic             enable,
    output logic [N-1:0]     onehot
);

    // NOTE: every bit is assigned on every pass, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            onehot[i] = enable && (index == IDX_W'(i));
        end
    end

endmodule

// File: rtl/config_frame_loader.sv
// Decodes a byte-wide framed configuration bitstream into one-hot per-tile
// write strobes with broadcast address and data.
module config_frame_loader
    import cfg_loader_pkg::*;
#(
    parameter int NB_TILES = 16,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8
) (
    input  logic                conf,
    input  logic                reset,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NB_TILES-1:0] select_tile,
    output logic [ADDR_W-1:0]   address_tile,
    output logic [DATA_W-1:0]   data_tile,
    output logic                cfg_done,
    output logic                cfg_err
);

    localparam logic [7:0] NB_TILES_B = 8'(NB_TILES);

    state_t              state, state_d;
    logic [7:0]          tile_q;
    logic                skip_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          cnt_q;
    logic [NB_TILES-1:0] sel_d;
    logic                accept;
    logic                tile_ok;
    logic                is_eob;

    assign in_ready = (state != IDLE) && (state != DONE);
    assign cfg_done = (state == DONE);
    assign accept   = in_valid && in_ready;
    assign is_eob   = (in_data == EOB_MARKER);
    assign tile_ok  = (in_data < NB_TILES_B);

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge conf or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    state_d = HDR_T;
            HDR_T:   if (accept) state_d = is_eob ? DONE : HDR_AH;
            HDR_AH:  if (accept) state_d = HDR_AL;
            HDR_AL:  if (accept) state_d = HDR_LEN;
            HDR_LEN: if (accept) state_d = DATA;
            DATA:    if (accept && cnt_q == 8'd0) state_d = HDR_T;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Frames addressed to a bad tile still run through DATA with the strobe
    // suppressed, so the byte count keeps the stream aligned.
    cfg_onehot_dec #(
        .N     (NB_TILES),
        .IDX_W (8)
    ) u_dec (
        .index  (tile_q),
        .enable (accept && (state == DATA) && !skip_q),
        .onehot (sel_d)
    );

    always_ff @(posedge conf or negedge reset) begin
        if (!reset) begin
            tile_q       <= '0;
            skip_q       <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            select_tile  <= '0;
            address_tile <= '0;
            data_tile    <= '0;
            cfg_err      <= 1'b0;
        end else begin
            select_tile <= sel_d;
            if (accept) begin
                unique case (state)
                    HDR_T: begin
                        if (!is_eob) begin
                            tile_q <= in_data;
                            skip_q <= !tile_ok;
                            if (!tile_ok) cfg_err <= 1'b1;
                        end
                    end
                    // Only the low ADDR_W-8 bits of AH are kept.
                    HDR_AH:  addr_q      <= ADDR_W'({in_data, 8'h00});
                    HDR_AL:  addr_q[7:0] <= in_data;
                    HDR_LEN: cnt_q       <= in_data;
                    DATA: begin
                        address_tile <= addr_q;
                        data_tile    <= in_data;
                        addr_q       <= addr_q + ADDR_W'(1);
                        cnt_q        <= cnt_q - 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed self-checking bench for config_frame_loader (NB_TILES=16, ADDR_W=10).
module tb_config_frame_loader;

    logic        conf;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] select_tile;
    logic [9:0]  address_tile;
    logic [7:0]  data_tile;
    logic        cfg_done;
    logic        cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    config_frame_loader #(
        .NB_TILES (16),
        .ADDR_W   (10),
        .DATA_W   (8)
    ) dut (
        .conf         (conf),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .select_tile  (select_tile),
        .address_tile (address_tile),
        .data_tile    (data_tile),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err)
    );

    initial conf = 1'b0;
    always #5 conf = ~conf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte from the falling edge, then sample 1 unit after the rising edge.
    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge conf);
        in_valid = v;
        in_data  = d;
        @(posedge conf);
        #1;
    endtask

    task automatic header(input logic [7:0] t, input logic [7:0] ah,
                          input logic [7:0] al, input logic [7:0] l);
        drive(1'b1, t);
        drive(1'b1, ah);
        drive(1'b1, al);
        drive(1'b1, l);
    endtask

    task automatic expect_wr(input string tag, input logic [15:0] sel,
                             input logic [9:0] addr, input logic [7:0] data);
        check({tag, ".sel"},  32'(select_tile),  32'(sel));
        check({tag, ".addr"}, 32'(address_tile), 32'(addr));
        check({tag, ".data"}, 32'(data_tile),    32'(data));
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge conf);
        #1;
        expect_wr("rst", 16'h0000, 10'h000, 8'h00);
        check("rst.done",  32'(cfg_done), 32'd0);
        check("rst.err",   32'(cfg_err),  32'd0);
        check("rst.ready", 32'(in_ready), 32'd0);

        @(negedge conf);
        reset = 1'b1;
        #1;
        check("rel.ready0", 32'(in_ready), 32'd0);
        @(posedge conf);
        #1;
        check("rel.ready1", 32'(in_ready), 32'd1);

        // Single write to tile 3 at 0x123.
        header(8'd3, 8'h01, 8'h23, 8'h00);
        check("single.hdr_nostb", 32'(select_tile), 32'd0);
        drive(1'b1, 8'hA5);
        expect_wr("single", 16'h0008, 10'h123, 8'hA5);
        drive(1'b0, 8'h00);
        expect_wr("single.hold", 16'h0000, 10'h123, 8'hA5);

        // Burst with address wrap; AH upper bits must be ignored.
        header(8'd0, 8'hFF, 8'hFE, 8'h03);
        drive(1'b1, 8'h11);
        expect_wr("burst0", 16'h0001, 10'h3FE, 8'h11);
        drive(1'b1, 8'h22);
        expect_wr("burst1", 16'h0001, 10'h3FF, 8'h22);
        drive(1'b1, 8'h33);
        expect_wr("burst2", 16'h0001, 10'h000, 8'h33);
        drive(1'b1, 8'h44);
        expect_wr("burst3", 16'h0001, 10'h001, 8'h44);
        drive(1'b0, 8'h00);
        check("burst.end", 32'(select_tile), 32'd0);
        check("burst.err", 32'(cfg_err), 32'd0);

        // Bad tile 20: data consumed silently, then a valid frame to tile 1.
        drive(1'b1, 8'd20);
        check("bad.err", 32'(cfg_err), 32'd1);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h10);
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h55);
        check("bad.d0", 32'(select_tile), 32'd0);
        drive(1'b1, 8'h66);
        check("bad.d1", 32'(select_tile), 32'd0);
        header(8'd1, 8'h00, 8'h40, 8'h00);
        drive(1'b1, 8'h77);
        expect_wr("after_bad", 16'h0002, 10'h040, 8'h77);
        check("after_bad.err", 32'(cfg_err), 32'd1);

        // Throttled data: strobes only on accepted bytes.
        header(8'd2, 8'h01, 8'h00, 8'h02);
        drive(1'b1, 8'h81);
        expect_wr("thr0", 16'h0004, 10'h100, 8'h81);
        drive(1'b0, 8'h99);
        expect_wr("thr_gap0", 16'h0000, 10'h100, 8'h81);
        drive(1'b1, 8'h82);
        expect_wr("thr1", 16'h0004, 10'h101, 8'h82);
        drive(1'b0, 8'h99);
        check("thr_gap1", 32'(select_tile), 32'd0);
        drive(1'b1, 8'h83);
        expect_wr("thr2", 16'h0004, 10'h102, 8'h83);
        drive(1'b0, 8'h00);
        check("thr.end", 32'(select_tile), 32'd0);

        // Reset asserted after 2 of 4 data bytes.
        header(8'd5, 8'h00, 8'h20, 8'h03);
        drive(1'b1, 8'hC1);
        expect_wr("mid0", 16'h0020, 10'h020, 8'hC1);
        drive(1'b1, 8'hC2);
        expect_wr("mid1", 16'h0020, 10'h021, 8'hC2);
        #2;
        reset = 1'b0;
        #1;
        expect_wr("mid.rst", 16'h0000, 10'h000, 8'h00);
        check("mid.rst_err",   32'(cfg_err),  32'd0);
        check("mid.rst_ready", 32'(in_ready), 32'd0);
        @(posedge conf);
        #1;
        check("mid.rst_nostb", 32'(select_tile), 32'd0);
        @(negedge conf);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge conf);
        #1;
        check("mid.ready", 32'(in_ready), 32'd1);
        header(8'd6, 8'h00, 8'h07, 8'h00);
        drive(1'b1, 8'hE6);
        expect_wr("post_rst", 16'h0040, 10'h007, 8'hE6);

        // End-of-bitstream marker.
        drive(1'b1, 8'hFF);
        check("eob.done",  32'(cfg_done),    32'd1);
        check("eob.ready", 32'(in_ready),    32'd0);
        check("eob.sel",   32'(select_tile), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h12 + i));
            check("eob.ign_sel",  32'(select_tile), 32'd0);
        end
        expect_wr("eob.hold", 16'h0000, 10'h007, 8'hE6);
        check("eob.done_sticky", 32'(cfg_done), 32'd1);
        check("eob.ready_low",   32'(in_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
